// File: rtl/user_defined_types.sv
// Shared types for the maze game: endzone descriptor, round-controller state
// encoding and the coordinate / compare widths used by the endzone logic.
package user_defined_types;

   localparam int COORD_W  = 10;  // pixel coordinate width
   localparam int CMP_W    = 11;  // start+extent sums never overflow at this width
   localparam int FRAMES_W = 11;  // round frame counter width

   typedef struct packed {
      logic [COORD_W-1:0] rowstart;
      logic [COORD_W-1:0] colstart;
      logic [COORD_W-1:0] width;
      logic [COORD_W-1:0] length;
   } endzone_struct;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_SCAN,
      ST_WIN,
      ST_TIMEOUT
   } endzone_ctrl_state_t;

endpackage

// File: rtl/endzone_point_test.sv
// Combinational test of one point against one endzone. A zone with zero
// width or zero length is treated as disabled and never reports a hit.
module endzone_point_test
   import user_defined_types::*;
(
   input  endzone_struct      zone,
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] col,
   output logic               hit
);

   logic [CMP_W-1:0] row_ext;
   logic [CMP_W-1:0] col_ext;
   logic [CMP_W-1:0] row_lo;
   logic [CMP_W-1:0] col_lo;
   logic [CMP_W-1:0] row_hi;
   logic [CMP_W-1:0] col_hi;
   logic             enabled;

   assign row_ext = {1'b0, row};
   assign col_ext = {1'b0, col};
   assign row_lo  = {1'b0, zone.rowstart};
   assign col_lo  = {1'b0, zone.colstart};
   // Exclusive upper bounds; one extra bit keeps e.g. 1000+100 from wrapping.
   assign row_hi  = {1'b0, zone.rowstart} + {1'b0, zone.width};
   assign col_hi  = {1'b0, zone.colstart} + {1'b0, zone.length};

   assign enabled = (zone.width != '0) && (zone.length != '0);

   assign hit = enabled
             && (row_ext >= row_lo) && (row_ext < row_hi)
             && (col_ext >= col_lo) && (col_ext < col_hi);

endmodule

// File: rtl/endzone_round_ctrl.sv
// Maze-game round controller: map latch, round timer and a once-per-frame
// sequential scan of the endzone array. Build option ENDZONE_CTRL_SCORE_EN
// adds a saturating count of rounds won on the wins output.
module endzone_round_ctrl
   import user_defined_types::*;
#(
   parameter  int NUM_ZONES    = 4,
   parameter  int ROUND_FRAMES = 1800,
   parameter  int HOLD_FRAMES  = 120,
   localparam int IDX_W        = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                map_req,
   input  logic                frame_tick,
   input  logic [COORD_W-1:0]  player_row,
   input  logic [COORD_W-1:0]  player_col,
   input  endzone_struct       endzones [NUM_ZONES],
   output logic                map_sel,
   output logic                playing,
   output logic                win,
   output logic                timeout,
   output logic [IDX_W-1:0]    zone_hit,
   output logic [FRAMES_W-1:0] frames_left,
   output logic [7:0]          wins
);

   localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   endzone_ctrl_state_t state;
   endzone_ctrl_state_t next_state;

   logic [IDX_W-1:0]    idx;
   logic [COORD_W-1:0]  row_snap;
   logic [COORD_W-1:0]  col_snap;
   logic                map_sel_q;
   logic [IDX_W-1:0]    zone_hit_q;
   logic [FRAMES_W-1:0] frames_left_q;
   logic [HOLD_W-1:0]   hold_cnt;

   endzone_struct       cur_zone;
   logic                zone_match;
   logic                last_zone;
   logic                hold_done;
   logic [FRAMES_W-1:0] frames_dec;

   // Single comparator shared by every zone; idx walks the array during SCAN.
   assign cur_zone = endzones[idx];

   endzone_point_test u_point_test (
      .zone (cur_zone),
      .row  (row_snap),
      .col  (col_snap),
      .hit  (zone_match)
   );

   assign last_zone  = (idx == IDX_W'(NUM_ZONES - 1));
   assign hold_done  = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
   assign frames_dec = frames_left_q - FRAMES_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets its default before the case so no path infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_LOAD;
         end
         ST_LOAD: begin
            next_state = ST_PLAY;
         end
         ST_PLAY: begin
            if (frame_tick) next_state = ST_SCAN;
         end
         ST_SCAN: begin
            // A hit beats the timer, so a hit on the final frame still wins.
            if (zone_match) begin
               next_state = ST_WIN;
            end else if (last_zone) begin
               next_state = (frames_dec == '0) ? ST_TIMEOUT : ST_PLAY;
            end
         end
         ST_WIN, ST_TIMEOUT: begin
            if (frame_tick && hold_done) next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx           <= '0;
         row_snap      <= '0;
         col_snap      <= '0;
         map_sel_q     <= 1'b0;
         zone_hit_q    <= '0;
         frames_left_q <= '0;
         hold_cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) map_sel_q <= map_req;
            end
            ST_LOAD: begin
               frames_left_q <= FRAMES_W'(ROUND_FRAMES);
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  row_snap <= player_row;
                  col_snap <= player_col;
                  idx      <= '0;
               end
            end
            ST_SCAN: begin
               if (zone_match) begin
                  zone_hit_q <= idx;
               end else if (last_zone) begin
                  frames_left_q <= frames_dec;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_WIN, ST_TIMEOUT: begin
               if (frame_tick) begin
                  hold_cnt <= hold_done ? '0 : hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef ENDZONE_CTRL_SCORE_EN
   logic [7:0] wins_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wins_q <= '0;
      end else if ((state == ST_SCAN) && zone_match && (wins_q != 8'hFF)) begin
         wins_q <= wins_q + 8'd1;
      end
   end

   assign wins = wins_q;
`else
   assign wins = '0;
`endif

   assign map_sel     = map_sel_q;
   assign playing     = (state == ST_PLAY) || (state == ST_SCAN);
   assign win         = (state == ST_WIN);
   assign timeout     = (state == ST_TIMEOUT);
   assign zone_hit    = zone_hit_q;
   assign frames_left = frames_left_q;

endmodule

// File: tb/tb_endzone_round_ctrl.sv
// Self-checking bench for endzone_round_ctrl: directed rounds followed by
// randomized rounds, all compared against a round-level behavioural model.
`timescale 1ns/1ps
module tb_endzone_round_ctrl;
   import user_defined_types::*;

   localparam int NZ = 4;
   localparam int RF = 3;
   localparam int HF = 5;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        start      = 1'b0;
   logic        map_req    = 1'b0;
   logic        frame_tick = 1'b0;
   logic [9:0]  player_row = '0;
   logic [9:0]  player_col = '0;
   endzone_struct zones [NZ];

   logic        map_sel;
   logic        playing;
   logic        win;
   logic        timeout;
   logic [1:0]  zone_hit;
   logic [10:0] frames_left;
   logic [7:0]  wins;

   int checks = 0;
   int errors = 0;

   // Round-level model of what the controller should be showing.
   int exp_frames = 0;
   int exp_zone   = 0;
   int wins_cnt   = 0;
   bit exp_map    = 1'b0;
   bit exp_play   = 1'b0;
   bit exp_win    = 1'b0;
   bit exp_to     = 1'b0;

   endzone_round_ctrl #(
      .NUM_ZONES    (NZ),
      .ROUND_FRAMES (RF),
      .HOLD_FRAMES  (HF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .map_req     (map_req),
      .frame_tick  (frame_tick),
      .player_row  (player_row),
      .player_col  (player_col),
      .endzones    (zones),
      .map_sel     (map_sel),
      .playing     (playing),
      .win         (win),
      .timeout     (timeout),
      .zone_hit    (zone_hit),
      .frames_left (frames_left),
      .wins        (wins)
   );

   always #5 clk = ~clk;

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic endzone_struct mk(input int rs, input int cs, input int w, input int l);
      endzone_struct z;
      z.rowstart = 10'(rs);
      z.colstart = 10'(cs);
      z.width    = 10'(w);
      z.length   = 10'(l);
      return z;
   endfunction

   // Behavioural stand-in for the endzone factory.
   task automatic load_map(input bit m);
      if (!m) begin
         zones[0] = mk(0,   0,   75, 75);
         zones[1] = mk(0,   565, 75, 75);
         zones[2] = mk(405, 0,   75, 75);
         zones[3] = mk(405, 565, 75, 75);
      end else begin
         zones[0] = mk(200, 280, 80, 80);
         for (int i = 1; i < NZ; i++) zones[i] = mk(0, 0, 0, 0);
      end
   endtask

   // Lowest enabled zone containing (r,c), or -1.
   function automatic int model_hit(input int r, input int c);
      int rs, cs, w, l;
      for (int i = 0; i < NZ; i++) begin
         rs = int'(zones[i].rowstart);
         cs = int'(zones[i].colstart);
         w  = int'(zones[i].width);
         l  = int'(zones[i].length);
         if (w != 0 && l != 0 && r >= rs && r < rs + w && c >= cs && c < cs + l) return i;
      end
      return -1;
   endfunction

   function automatic int exp_wins();
`ifdef ENDZONE_CTRL_SCORE_EN
      return (wins_cnt > 255) ? 255 : wins_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".playing"},     32'(playing),     32'(exp_play));
      check({tag, ".win"},         32'(win),         32'(exp_win));
      check({tag, ".timeout"},     32'(timeout),     32'(exp_to));
      check({tag, ".zone_hit"},    32'(zone_hit),    exp_zone);
      check({tag, ".frames_left"}, 32'(frames_left), exp_frames);
      check({tag, ".wins"},        32'(wins),        exp_wins());
      check({tag, ".map_sel"},     32'(map_sel),     32'(exp_map));
   endtask

   task automatic model_reset();
      exp_frames = 0;
      exp_zone   = 0;
      wins_cnt   = 0;
      exp_map    = 1'b0;
      exp_play   = 1'b0;
      exp_win    = 1'b0;
      exp_to     = 1'b0;
   endtask

   // Pulse start in IDLE; optionally drop a frame tick into the LOAD cycle.
   task automatic start_round(input bit m, input bit load, input bit tick_load);
      if (load) load_map(m);
      start   = 1'b1;
      map_req = m;
      cyc(1);
      start   = 1'b0;
      map_req = 1'($urandom);
      exp_map = m;
      check_all("load");
      frame_tick = tick_load;
      cyc(1);
      frame_tick = 1'b0;
      exp_play   = 1'b1;
      exp_frames = RF;
      check_all("play_entry");
      if (tick_load) begin
         cyc(NZ + 1);
         check_all("load_tick_ignored");
      end
   endtask

   // One frame tick in PLAY; checks the cycle before and the cycle of the result.
   task automatic tick_and_wait(input int r, input int c, input bit extra);
      int h;
      int n_pre;
      player_row = 10'(r);
      player_col = 10'(c);
      h = model_hit(int'(player_row), int'(player_col));
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = extra;
      player_row = 10'($urandom);
      player_col = 10'($urandom);
      n_pre = (h >= 0) ? h : NZ - 1;
      for (int k = 0; k < n_pre; k++) begin
         cyc(1);
         frame_tick = 1'b0;
      end
      check_all("scan_pre");
      cyc(1);
      frame_tick = 1'b0;
      if (h >= 0) begin
         exp_play = 1'b0;
         exp_win  = 1'b1;
         exp_zone = h;
         wins_cnt++;
      end else begin
         exp_frames--;
         if (exp_frames == 0) begin
            exp_play = 1'b0;
            exp_to   = 1'b1;
         end
      end
      check_all("scan_result");
   endtask

   task automatic hold_out();
      for (int k = 1; k <= HF; k++) begin
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
         if (k == HF) begin
            exp_win = 1'b0;
            exp_to  = 1'b0;
         end
         check_all($sformatf("hold%0d", k));
         cyc(1);
      end
   endtask

   initial begin
      int r, c, k;
      bit m;
      bit done;

      load_map(1'b0);
      cyc(2);
      reset = 1'b0;
      check_all("reset");

      // Map 0, player inside zone 0: win two cycles after the tick.
      start_round(1'b0, 1'b1, 1'b0);
      tick_and_wait(10, 10, 1'b0);
      hold_out();

      // Zone 0 edges: (74,74) inside, (75,75) outside.
      start_round(1'b0, 1'b1, 1'b0);
      tick_and_wait(74, 74, 1'b0);
      hold_out();
      start_round(1'b0, 1'b1, 1'b0);
      tick_and_wait(75, 75, 1'b0);
      tick_and_wait(240, 320, 1'b0);
      tick_and_wait(240, 320, 1'b0);
      hold_out();

      // Hit on the final frame wins, frames_left not decremented.
      start_round(1'b0, 1'b1, 1'b0);
      tick_and_wait(240, 320, 1'b0);
      tick_and_wait(240, 320, 1'b0);
      tick_and_wait(470, 630, 1'b0);
      hold_out();

      // Disabled zones at the origin, and an 11-bit span past 1023.
      zones[0] = mk(900, 900, 50, 50);
      zones[1] = mk(1000, 0, 100, 50);
      zones[2] = mk(0, 0, 0, 0);
      zones[3] = mk(0, 0, 0, 20);
      start_round(1'b0, 1'b0, 1'b0);
      tick_and_wait(0, 0, 1'b0);
      tick_and_wait(1020, 10, 1'b0);
      hold_out();

      // map_sel latched at start, ignored map_req/start/ticks in LOAD and SCAN.
      start_round(1'b1, 1'b1, 1'b1);
      start   = 1'b1;
      map_req = 1'b0;
      cyc(1);
      start   = 1'b0;
      check_all("start_ignored");
      tick_and_wait(10, 10, 1'b1);
      tick_and_wait(10, 10, 1'b0);
      tick_and_wait(10, 10, 1'b1);
      hold_out();
      check_all("map_sel_held_idle");
      start_round(1'b0, 1'b1, 1'b0);
      tick_and_wait(10, 600, 1'b0);
      hold_out();

      // Enough wins to reach saturation of the score counter.
      for (int i = 0; i < 260; i++) begin
         start_round(1'b0, 1'b1, 1'b0);
         tick_and_wait(10, 10, 1'b0);
         hold_out();
      end

      // Reset in the second SCAN cycle of a round that would hit zone 2.
      start_round(1'b0, 1'b1, 1'b0);
      player_row = 10'd410;
      player_col = 10'd10;
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      model_reset();
      check_all("mid_scan_reset");
      cyc(4);
      check_all("mid_scan_reset_quiet");

      // Randomized rounds, alternating factory maps with random zone arrays.
      for (int rnd = 0; rnd < 40; rnd++) begin
         m = 1'($urandom_range(0, 1));
         if (rnd % 2 == 1) begin
            for (int i = 0; i < NZ; i++) begin
               zones[i] = mk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                             ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 300)),
                             ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 300)));
            end
            start_round(m, 1'b0, 1'($urandom_range(0, 1)));
         end else begin
            start_round(m, 1'b1, 1'b0);
         end
         done = 1'b0;
         while (!done) begin
            k = int'($urandom_range(0, NZ - 1));
            if ($urandom_range(0, 3) == 0) begin
               r = int'($urandom_range(0, 1023));
               c = int'($urandom_range(0, 1023));
            end else begin
               r = int'(zones[k].rowstart) + int'($urandom_range(0, 1 + int'(zones[k].width))) - 1;
               c = int'(zones[k].colstart) + int'($urandom_range(0, 1 + int'(zones[k].length))) - 1;
            end
            tick_and_wait(r & 1023, c & 1023, 1'($urandom_range(0, 1)));
            if (exp_win || exp_to) begin
               done = 1'b1;
               hold_out();
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
